// File: rtl/wb_dac_channel_pkg.sv
// rtl/wb_dac_channel_pkg.sv - control-register bit map, DAC channel defaults and refill FSM states
package wb_dac_channel_pkg;

  // Control register layout shared with the acquisition channels.
  localparam int CONTROL_REG_ENABLE      = 0;
  localparam int CONTROL_REG_SIGNED_DATA = 1;

  // DAC channel defaults.
  localparam int DW_DEFAULT             = 32;
  localparam int DAC_DATA_WIDTH_DEFAULT = 8;
  localparam int SPW_DEFAULT            = DW_DEFAULT / DAC_DATA_WIDTH_DEFAULT;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

endpackage

// File: rtl/wb_dac_channel_if.sv
// rtl/wb_dac_channel_if.sv - SRAM burst-read and DAC sample handshake bundle
// master: the DAC channel (issues bursts, produces samples)
// slave : the SRAM read engine plus DAC front end
interface wb_dac_channel_if #(
  parameter int dw             = 32,
  parameter int DAC_DATA_WIDTH = 8,
  parameter int FIFO_DEPTH     = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                      sram_start;
  logic [CW-1:0]             sram_burst_len;
  logic [dw-1:0]             sram_data_in;
  logic                      sram_data_valid;
  logic                      sram_data_done;
  logic                      dac_sample_req;
  logic [DAC_DATA_WIDTH-1:0] dac_data;
  logic                      dac_data_valid;

  modport master (
    output sram_start, sram_burst_len, dac_data, dac_data_valid,
    input  sram_data_in, sram_data_valid, sram_data_done, dac_sample_req
  );

  modport slave (
    input  sram_start, sram_burst_len, dac_data, dac_data_valid,
    output sram_data_in, sram_data_valid, sram_data_done, dac_sample_req
  );
endinterface

// File: rtl/wb_dac_channel_fifo.sv
// rtl/wb_dac_channel_fifo.sv - word FIFO with registered read data and synchronous flush
// push/wr_data in, pop in (rd_data valid the cycle after), count/empty out, flush clears
module wb_dac_channel_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/wb_dac_data_disaggregation.sv
// rtl/wb_dac_data_disaggregation.sv - unpacks FIFO words into DAC samples, LSB sample first
// in : enable, clear, signed_data, fifo_empty, fifo_rd_data, sample_req
// out: fifo_pop, dac_data, dac_data_valid, underflow (sticky until clear)
module wb_dac_data_disaggregation #(
  parameter int dw             = 32,
  parameter int DAC_DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      clear,
  input  logic                      signed_data,
  input  logic                      fifo_empty,
  input  logic [dw-1:0]             fifo_rd_data,
  input  logic                      sample_req,
  output logic                      fifo_pop,
  output logic [DAC_DATA_WIDTH-1:0] dac_data,
  output logic                      dac_data_valid,
  output logic                      underflow
);
  localparam int SPW = dw / DAC_DATA_WIDTH;
  localparam int IW  = (SPW > 1) ? $clog2(SPW) : 1;

  logic [SPW-1:0][DAC_DATA_WIDTH-1:0] hold;
  logic                               hold_valid;
  logic                               load_pending;
  logic [IW-1:0]                      idx;
  logic [DAC_DATA_WIDTH-1:0]          sample;

  // load_pending covers the registered FIFO read so one word is not popped twice.
  assign fifo_pop = enable && !hold_valid && !load_pending && !fifo_empty;
  // Signed mode flips the MSB: two's complement to offset binary.
  assign sample   = hold[idx] ^ {signed_data, {(DAC_DATA_WIDTH-1){1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold           <= '0;
      hold_valid     <= 1'b0;
      load_pending   <= 1'b0;
      idx            <= '0;
      dac_data       <= '0;
      dac_data_valid <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      dac_data_valid <= 1'b0;
      if (clear) begin
        hold         <= '0;
        hold_valid   <= 1'b0;
        load_pending <= 1'b0;
        idx          <= '0;
        underflow    <= 1'b0;
      end else begin
        load_pending <= fifo_pop;
        if (load_pending) begin
          hold       <= fifo_rd_data;
          hold_valid <= 1'b1;
        end
        if (enable && sample_req) begin
          dac_data_valid <= 1'b1;
          if (hold_valid) begin
            dac_data <= sample;
            if (idx == IW'(SPW - 1)) begin
              idx        <= '0;
              hold_valid <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            underflow <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: rtl/wb_dac_channel.sv
// rtl/wb_dac_channel.sv - DAC playback channel: SRAM burst refill into word FIFO, sample unpacking
// wb_clk/wb_rst       : clock, asynchronous active-low reset
// master_enable, control, fifo_number_samples_terminal : enables, signed select, refill threshold
// bus (master)        : sram_start/burst_len out, sram_data_in/valid/done in, dac_sample_req in, dac_data/valid out
// underflow, fifo_empty : status
module wb_dac_channel
  import wb_dac_channel_pkg::*;
#(
  parameter int dw             = DW_DEFAULT,
  parameter int DAC_DATA_WIDTH = DAC_DATA_WIDTH_DEFAULT,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                        wb_clk,
  input  logic                        wb_rst,
  input  logic                        master_enable,
  input  logic [dw-1:0]               control,
  input  logic [$clog2(FIFO_DEPTH):0] fifo_number_samples_terminal,
  wb_dac_channel_if.master            bus,
  output logic                        underflow,
  output logic                        fifo_empty
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fill_state_t   state;
  logic          enable, flush, push, pop;
  logic [CW-1:0] count;
  logic [dw-1:0] rd_data;
  logic          sram_start_q;
  logic [CW-1:0] sram_burst_len_q;
  logic          unused_control;

  assign enable         = master_enable & control[CONTROL_REG_ENABLE];
  // Flushing waits for IDLE so an issued burst always runs to sram_data_done.
  assign flush          = !enable && (state == IDLE);
  assign push           = (state == FILL) && bus.sram_data_valid;
  assign unused_control = ^control[dw-1:CONTROL_REG_SIGNED_DATA+1];

  assign bus.sram_start     = sram_start_q;
  assign bus.sram_burst_len = sram_burst_len_q;

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state            <= IDLE;
      sram_start_q     <= 1'b0;
      sram_burst_len_q <= '0;
    end else begin
      sram_start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && (count <= fifo_number_samples_terminal)) begin
            state            <= FILL;
            sram_start_q     <= 1'b1;
            sram_burst_len_q <= CW'(FIFO_DEPTH) - count;
          end
        end
        FILL: begin
          if (bus.sram_data_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  wb_dac_channel_fifo #(
    .WIDTH(dw),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (wb_clk),
    .rst_n  (wb_rst),
    .flush  (flush),
    .push   (push),
    .wr_data(bus.sram_data_in),
    .pop    (pop),
    .rd_data(rd_data),
    .count  (count),
    .empty  (fifo_empty)
  );

  wb_dac_data_disaggregation #(
    .dw            (dw),
    .DAC_DATA_WIDTH(DAC_DATA_WIDTH)
  ) u_disagg (
    .clk           (wb_clk),
    .rst_n         (wb_rst),
    .enable        (enable),
    .clear         (flush),
    .signed_data   (control[CONTROL_REG_SIGNED_DATA]),
    .fifo_empty    (fifo_empty),
    .fifo_rd_data  (rd_data),
    .sample_req    (bus.dac_sample_req),
    .fifo_pop      (pop),
    .dac_data      (bus.dac_data),
    .dac_data_valid(bus.dac_data_valid),
    .underflow     (underflow)
  );
endmodule

// File: tb/tb_wb_dac_channel.sv
// tb/tb_wb_dac_channel.sv - self-checking bench for wb_dac_channel
module tb_wb_dac_channel;
  import wb_dac_channel_pkg::*;

  localparam int DW = 32, W = 8, DEPTH = 16, CW = 5, SPW = 4;

  logic          wb_clk = 1'b0;
  logic          wb_rst = 1'b0;
  logic          master_enable = 1'b0;
  logic [DW-1:0] control = '0;
  logic [CW-1:0] terminal = 5'd4;
  logic          underflow, fifo_empty;

  wb_dac_channel_if #(.dw(DW), .DAC_DATA_WIDTH(W), .FIFO_DEPTH(DEPTH)) bus ();

  wb_dac_channel #(.dw(DW), .DAC_DATA_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
    .wb_clk                      (wb_clk),
    .wb_rst                      (wb_rst),
    .master_enable               (master_enable),
    .control                     (control),
    .fifo_number_samples_terminal(terminal),
    .bus                         (bus),
    .underflow                   (underflow),
    .fifo_empty                  (fifo_empty)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct {
    logic [DW-1:0] word;
    logic          sgn;
    logic [SPW-1:0][W-1:0] exp;
  } vec_t;

  vec_t          tbl [4];
  int            tests = 0, fails = 0;
  logic [W-1:0]  exp_q [$];
  logic [DW-1:0] word_q [$];
  logic [W-1:0]  model_last = '0;
  int            model_idx = 0;
  int            start_cnt = 0, valid_cnt = 0;
  logic [CW-1:0] last_len = '0;
  logic          prev_start = 1'b0, prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  always @(negedge wb_clk) begin
    if (bus.sram_start) begin
      start_cnt++;
      last_len = bus.sram_burst_len;
      check("sram_start_one_cycle", 32'(prev_start), 32'd0);
    end
    prev_start = bus.sram_start;
    if (bus.dac_data_valid) begin
      valid_cnt++;
      check("valid_one_cycle", 32'(prev_valid), 32'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got dac_data 0x%0h, expected no strobe", bus.dac_data);
      end else begin
        check("dac_data", 32'(bus.dac_data), 32'(exp_q.pop_front()));
      end
    end
    prev_valid = bus.dac_data_valid;
  end

  // Reference sample stream: words in arrival order, LSB sample first.
  task automatic model_next(output logic [W-1:0] s);
    logic [DW-1:0] w;
    if (word_q.size() == 0) begin
      s = model_last;
    end else begin
      w = word_q[0];
      s = w[model_idx*W +: W];
      if (control[CONTROL_REG_SIGNED_DATA]) s[W-1] = ~s[W-1];
      model_idx++;
      if (model_idx == SPW) begin
        model_idx = 0;
        void'(word_q.pop_front());
      end
    end
    model_last = s;
  endtask

  task automatic strobe_exp(input logic [W-1:0] e, input int gap);
    exp_q.push_back(e);
    model_last = e;
    bus.dac_sample_req = 1'b1;
    tick();
    bus.dac_sample_req = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic strobe_model(input int gap);
    logic [W-1:0] s;
    model_next(s);
    strobe_exp(s, gap);
  endtask

  task automatic send_word(input logic [DW-1:0] w, input bit done);
    bus.sram_data_in    = w;
    bus.sram_data_valid = 1'b1;
    bus.sram_data_done  = done;
    word_q.push_back(w);
    tick();
    bus.sram_data_valid = 1'b0;
    bus.sram_data_done  = 1'b0;
  endtask

  task automatic wait_start(input string name, input int exp_cnt, input int exp_len);
    int n = 0;
    while (start_cnt < exp_cnt && n < 50) begin
      tick();
      n++;
    end
    check({name, "_count"}, 32'(start_cnt), 32'(exp_cnt));
    check({name, "_len"}, 32'(last_len), 32'(exp_len));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] s;
    int vc;

    tbl[0] = '{32'h80FF7F01, 1'b0, 32'h80FF7F01};
    tbl[1] = '{32'h80FF7F01, 1'b1, 32'h007FFF81};
    tbl[2] = '{32'h12345678, 1'b0, 32'h12345678};
    tbl[3] = '{32'hA5C3E10F, 1'b1, 32'h2543618F};

    bus.sram_data_in    = '0;
    bus.sram_data_valid = 1'b0;
    bus.sram_data_done  = 1'b0;
    bus.dac_sample_req  = 1'b0;

    // Reset values
    repeat (3) tick();
    check("rst_sram_start", 32'(bus.sram_start), 32'd0);
    check("rst_burst_len", 32'(bus.sram_burst_len), 32'd0);
    check("rst_dac_data", 32'(bus.dac_data), 32'd0);
    check("rst_dac_valid", 32'(bus.dac_data_valid), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_fifo_empty", 32'(fifo_empty), 32'd1);
    wb_rst = 1'b1;
    repeat (3) tick();
    check("no_start_disabled", 32'(start_cnt), 32'd0);

    // Initial fill: one start of 16 words
    master_enable = 1'b1;
    control       = 32'h1;
    wait_start("start1", 1, 16);
    for (int i = 0; i < 16; i++)
      send_word((i < 4) ? tbl[i].word : $urandom, i == 15);
    // Data valid while IDLE must be ignored
    bus.sram_data_in    = 32'hDEADBEEF;
    bus.sram_data_valid = 1'b1;
    tick();
    bus.sram_data_valid = 1'b0;
    repeat (6) tick();
    check("no_second_start", 32'(start_cnt), 32'd1);
    check("fifo_filled", 32'(fifo_empty), 32'd0);

    // Table: unsigned/signed unpacking, strobes 4 cycles apart
    for (int i = 0; i < 4; i++) begin
      control[CONTROL_REG_SIGNED_DATA] = tbl[i].sgn;
      for (int j = 0; j < SPW; j++) begin
        model_next(s);
        strobe_exp(tbl[i].exp[j], 3);
      end
    end
    control = 32'h1;

    // Drain to count 5 (no start), then count 4 (start of 12)
    for (int k = 0; k < 24; k++) strobe_model(3);
    check("no_start_count5", 32'(start_cnt), 32'd1);
    for (int k = 0; k < 4; k++) strobe_model(3);
    wait_start("refill", 2, 12);

    // Refill with strobes interleaved; a pop lands during a push
    for (int k = 0; k < 12; k++) begin
      bus.sram_data_in    = $urandom;
      bus.sram_data_valid = 1'b1;
      bus.sram_data_done  = (k == 11);
      word_q.push_back(bus.sram_data_in);
      if (k % 3 == 0) begin
        model_next(s);
        exp_q.push_back(s);
        bus.dac_sample_req = 1'b1;
      end else begin
        bus.dac_sample_req = 1'b0;
      end
      tick();
    end
    bus.sram_data_valid = 1'b0;
    bus.sram_data_done  = 1'b0;
    bus.dac_sample_req  = 1'b0;
    repeat (2) tick();
    check("refill_single_start", 32'(start_cnt), 32'd2);
    // Count must now be 15: refill exactly after 11 more words
    for (int k = 0; k < 40; k++) strobe_model(3);
    check("no_start_after_refill", 32'(start_cnt), 32'd2);
    for (int k = 0; k < 4; k++) strobe_model(3);
    wait_start("refill2", 3, 12);

    // Disable mid-burst after 5 of 12 words
    for (int k = 0; k < 5; k++) send_word($urandom, 1'b0);
    control = 32'h0;
    for (int k = 0; k < 6; k++) send_word($urandom, 1'b0);
    check("no_flush_during_fill", 32'(fifo_empty), 32'd0);
    send_word($urandom, 1'b1);
    repeat (2) tick();
    check("flushed_after_done", 32'(fifo_empty), 32'd1);
    check("dac_data_held", 32'(bus.dac_data), 32'(model_last));
    word_q.delete();
    model_idx = 0;

    // Underflow: FIFO and holding register empty
    control = 32'h1;
    wait_start("start_empty", 4, 16);
    vc = valid_cnt;
    strobe_model(3);
    check("underflow_set", 32'(underflow), 32'd1);
    check("underflow_valid", 32'(valid_cnt), 32'(vc + 1));
    control = 32'h0;
    bus.sram_data_done = 1'b1;
    tick();
    bus.sram_data_done = 1'b0;
    repeat (2) tick();
    check("underflow_cleared", 32'(underflow), 32'd0);
    check("fifo_flushed", 32'(fifo_empty), 32'd1);
    vc = valid_cnt;
    bus.dac_sample_req = 1'b1;
    tick();
    bus.dac_sample_req = 1'b0;
    repeat (3) tick();
    check("strobe_ignored_disabled", 32'(valid_cnt), 32'(vc));
    check("no_underflow_disabled", 32'(underflow), 32'd0);

    // Asynchronous reset mid-burst
    control = 32'h1;
    wait_start("start_rst", 5, 16);
    strobe_model(3);
    for (int k = 0; k < 3; k++) send_word($urandom, 1'b0);
    tick();
    check("pre_rst_underflow", 32'(underflow), 32'd1);
    check("pre_rst_fifo", 32'(fifo_empty), 32'd0);
    @(negedge wb_clk);
    #2;
    wb_rst = 1'b0;
    #1;
    check("arst_burst_len", 32'(bus.sram_burst_len), 32'd0);
    check("arst_sram_start", 32'(bus.sram_start), 32'd0);
    check("arst_dac_data", 32'(bus.dac_data), 32'd0);
    check("arst_underflow", 32'(underflow), 32'd0);
    check("arst_fifo_empty", 32'(fifo_empty), 32'd1);
    repeat (2) tick();
    wb_rst = 1'b1;
    repeat (2) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_dac_channel.md
Name: wb_dac_channel

Overview:
Playback counterpart of the DAQ acquisition channel. It fetches 32-bit packed sample words from SRAM in bursts and buffers them in a word FIFO. It then unpacks each word into DAC_DATA_WIDTH-bit samples, one per DAC sample strobe. It sits between the SRAM read engine and a DAC interface, and shares the control-register layout and the FIFO threshold scheme with the acquisition channels.

Parameters:
dw, 32, data/word width of the SRAM and control interfaces
DAC_DATA_WIDTH, 8, sample width; dw must be an integer multiple of it (SPW = dw/DAC_DATA_WIDTH samples per word)
FIFO_DEPTH, 16, word FIFO depth, power of two

Ports:
wb_clk  input  1  single system clock; all logic is on its rising edge
wb_rst  input  1  asynchronous active-low reset
master_enable  input  1  global enable
control  input  dw  channel control register; bit0 is the channel enable, bit `CONTROL_REG_SIGNED_DATA selects signed data
sram_data_in  input  dw  word returned by SRAM
sram_data_valid  input  1  one-cycle qualifier for sram_data_in
sram_data_done  input  1  one-cycle pulse marking the end of the current burst
fifo_number_samples_terminal  input  $clog2(FIFO_DEPTH)+1  refill threshold, in words
dac_sample_req  input  1  one-cycle sample strobe, already synchronous to wb_clk
sram_start  output  1  one-cycle burst request
sram_burst_len  output  $clog2(FIFO_DEPTH)+1  number of words requested; stable from sram_start until sram_data_done
dac_data  output  DAC_DATA_WIDTH  sample to DAC, offset binary
dac_data_valid  output  1  one-cycle strobe, asserted when dac_data updates
underflow  output  1  sticky; set when a sample strobe finds no data
fifo_empty  output  1  word FIFO empty

Behaviour:
- enable = master_enable & control[0].
- Reset values: sram_start=0, sram_burst_len=0, dac_data=0, dac_data_valid=0, underflow=0, fifo_empty=1, FSM in IDLE, FIFO count 0, holding register empty, sample index 0.

Refill FSM (states IDLE, FILL):
- IDLE -> FILL when enable && count <= fifo_number_samples_terminal.
  - On that transition: sram_start pulses for one cycle and sram_burst_len latches FIFO_DEPTH - count.
  - Count is sampled in the same cycle, so a pop in that cycle only adds slack.
- FILL:
  - Each sram_data_valid pushes sram_data_in into the FIFO.
  - A push while the FIFO is full drops the word; this is a protocol error that cannot occur when sram_burst_len is honoured.
  - FILL -> IDLE on sram_data_done.
  - sram_data_valid and sram_data_done in the same cycle: the word is pushed, then the FSM exits.
  - sram_data_valid while in IDLE is ignored.
- enable deasserted in FILL: words are still accepted until sram_data_done (an issued burst is not aborted), then IDLE.
- enable low and FSM in IDLE: FIFO flushed, holding register cleared, sample index set to 0, underflow cleared. dac_data holds its last value.

Unpack path:
- Holding register plus hold_valid flag.
- When !hold_valid && !fifo_empty && enable: pop the FIFO. The word loads into the holding register 1 cycle later (registered FIFO read).
- On dac_sample_req with hold_valid:
  - dac_data = sample[idx], where idx 0 is bits [DAC_DATA_WIDTH-1:0], least-significant first.
  - dac_data_valid pulses in the cycle after the strobe.
  - idx increments.
  - When idx wraps from SPW-1 to 0, hold_valid clears. The refetch completes within 2 cycles, so back-to-back strobes need at least 3 cycles of spacing.
- Signed data (signed bit set): the sample MSB is inverted on output (two's complement to offset binary). Unsigned data passes through unchanged.
- On dac_sample_req without hold_valid:
  - dac_data repeats its previous value.
  - dac_data_valid still pulses.
  - underflow sets and stays set until enable falls or reset.
- dac_sample_req while enable is low is ignored: no valid pulse, no underflow.
- A pop and a push in the same cycle are both honoured; count is unchanged.
- Reset asserted mid-burst returns every register to its reset value immediately. The SRAM side must tolerate the abandoned burst.

Decomposition:
- The `CONTROL_REG_* bit indices stay in wb_dsp_slave_registers_include.vh.
- Add the DAC channel defaults (DAC_DATA_WIDTH, SPW) there as well.
- Reuse the existing fifo module for word buffering.
- One natural sub-module, wb_dac_data_disaggregation: holding register, index counter, sign conversion, underflow. It is the mirror of the acquisition aggregator.

Test Plan:
- Reset then enable with terminal=4: sram_start pulses once with sram_burst_len=16. Feed 16 words then done: fifo count 16, FSM back in IDLE, no second start.
- Word 0x80FF7F01, unsigned, 4 strobes spaced 4 cycles apart: dac_data = 0x01, 0x7F, 0xFF, 0x80, each with a one-cycle valid.
- Same word with the signed bit set: dac_data = 0x81, 0xFF, 0x7F, 0x00.
- Drain to count 4 with terminal=4: exactly one new sram_start with sram_burst_len=12. A push and a pop in the same cycle leave count unchanged.
- FIFO empty and holding register empty, one strobe: dac_data unchanged, dac_data_valid=1, underflow=1. Deassert control[0]: underflow=0 and the FIFO is flushed.
- Deassert enable mid-burst after 5 of 12 words: remaining words are accepted until done, then flush. Pull wb_rst low mid-burst: all outputs reach reset values without waiting for a clock edge.
